// File: rtl/vga_timing_gen.sv
// Purpose: 640x480@60 VGA sync generator; requests each visible pixel's colour one pixel ahead.
// Latency: CLK_DIV clks from the req edge to rgb/hsync/vsync for that pixel.
// Backpressure: none; free-running raster, the pixel generator must answer every req in time.
module vga_timing_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] next_color,
    output logic       req,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] rgb
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div;
    logic             tick;
    logic [9:0]       hcount;
    logic [9:0]       vcount;
    logic [9:0]       nh;
    logic [9:0]       nv;

    // Pixel-rate divider: tick marks the last system clock of each pixel period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign tick = (div == DIV_LAST);

    // Position the counters will take on the next tick, with line and frame wrap applied.
    always_comb begin
        nh = hcount + 10'd1;
        nv = vcount;
        if (hcount == H_LAST) begin
            nh = '0;
            nv = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
        end
    end

    // Raster counters; reset parks them on the last pixel so the first tick lands on (0,0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount <= H_LAST;
            vcount <= V_LAST;
        end else if (tick) begin
            hcount <= nh;
            vcount <= nv;
        end
    end

    // Request for the upcoming pixel is issued one pixel period before it is shown.
    assign col         = nh;
    assign row         = nv;
    assign req         = tick & ~rst & (nh < H_VIS) & (nv < V_VIS);
    assign frame_start = tick & ~rst & (nh == 10'd0) & (nv == 10'd0);

    // Output stage: syncs and blanked colour all describe the pixel the counters hold now.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            rgb   <= '0;
        end else if (tick) begin
            rgb   <= ((hcount < H_VIS) && (vcount < V_VIS)) ? next_color : 8'd0;
            hsync <= ~((hcount >= HS_START) && (hcount < HS_END));
            vsync <= ~((vcount >= VS_START) && (vcount < VS_END));
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full horizontal timing, vertical timing shortened to keep runs short.
module tb_vga_timing_gen;

    localparam int CD = 2;
    localparam int HV = 640, HF = 16, HS = 96, HB = 48;
    localparam int VV = 4,   VF = 1,  VS = 2,  VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int LINE  = HT * CD;
    localparam int FRAME = HT * VT * CD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] next_color = 8'd0;
    logic       req, frame_start, hsync, vsync;
    logic [9:0] col, row;
    logic [7:0] rgb;

    int n_checks = 0;
    int n_fail   = 0;
    int n        = 0;

    bit         pg_mode  = 1'b0;
    logic [7:0] pg_const = 8'hA5;
    logic [7:0] seed     = 8'h00;
    logic [7:0] pg_color = 8'h00;

    vga_timing_gen #(
        .CLK_DIV(CD), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .rst(rst), .next_color(next_color), .req(req), .col(col), .row(row),
        .frame_start(frame_start), .hsync(hsync), .vsync(vsync), .rgb(rgb)
    );

    always #5 clk = ~clk;

    // Pixel generator model: loads the colour of the requested pixel on the req edge.
    always @(posedge clk) if (req) pg_color <= pg_mode ? (col[7:0] ^ seed) : pg_const;

    typedef struct {
        bit         req, fs, hs, vs;
        int         col, row, drow;
        logic [7:0] rgb;
    } exp_t;

    function automatic logic [7:0] gen(int h);
        return pg_mode ? (8'(h) ^ seed) : pg_const;
    endfunction

    // Expected outputs n clocks after reset release, from the pixel index alone.
    function automatic exp_t model(int cyc);
        exp_t e;
        int k, r, hr, vr;
        bit tk;
        k     = cyc / CD;
        tk    = ((cyc + 1) % CD) == 0;
        e.col = k % HT;
        e.row = (k / HT) % VT;
        e.req = tk && e.col < HV && e.row < VV;
        e.fs  = tk && e.col == 0 && e.row == 0;
        r = k - 2;
        if (r < 0) begin
            e.hs = 1'b1; e.vs = 1'b1; e.rgb = 8'h00; e.drow = -1;
        end else begin
            hr = r % HT;
            vr = (r / HT) % VT;
            e.drow = vr;
            e.hs  = !(hr >= HV + HF && hr < HV + HF + HS);
            e.vs  = !(vr >= VV + VF && vr < VV + VF + VS);
            e.rgb = (hr < HV && vr < VV) ? gen(hr) : 8'h00;
        end
        return e;
    endfunction

    // Colour bus carries the loaded colour only into tick edges; anything else is noise.
    task automatic drive_color();
        if (((n + 1) % CD) == 0) next_color = pg_color;
        else                     next_color = 8'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
        drive_color();
    endtask

    task automatic release_reset();
        rst = 1'b0;
        n   = 0;
        drive_color();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_checks++; if (req !== 1'b0)         begin n_fail++; $display("FAIL rst_req: got %b want 0", req); end
        n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL rst_fs: got %b want 0", frame_start); end
        n_checks++; if (hsync !== 1'b1)       begin n_fail++; $display("FAIL rst_hsync: got %b want 1", hsync); end
        n_checks++; if (vsync !== 1'b1)       begin n_fail++; $display("FAIL rst_vsync: got %b want 1", vsync); end
        n_checks++; if (rgb !== 8'h00)        begin n_fail++; $display("FAIL rst_rgb: got %h want 00", rgb); end
        release_reset();
        n_checks++; if (req !== 1'b0)         begin n_fail++; $display("FAIL rel0_req: got %b want 0", req); end
        step();
        n_checks++; if (req !== 1'b1)         begin n_fail++; $display("FAIL first_req: got %b want 1", req); end
        n_checks++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL first_fs: got %b want 1", frame_start); end
        n_checks++; if (col !== 10'd0)        begin n_fail++; $display("FAIL first_col: got %0d want 0", col); end
        n_checks++; if (row !== 10'd0)        begin n_fail++; $display("FAIL first_row: got %0d want 0", row); end
        n_checks++; if (hsync !== 1'b1 || vsync !== 1'b1 || rgb !== 8'h00) begin
            n_fail++; $display("FAIL first_out: got hs=%b vs=%b rgb=%h want 1 1 00", hsync, vsync, rgb);
        end
    endtask

    // Starts at the first req after release (n=1) with a constant A5 colour source.
    task automatic test_line();
        int reqs = 0, on = 0, off = 0, exp_col = 0;
        logic [9:0] row0;
        exp_t e;
        row0 = row;
        while (n <= LINE + 3) begin
            e = model(n);
            n_checks++; if (req !== e.req) begin n_fail++; $display("FAIL line_req n=%0d: got %b want %b", n, req, e.req); end
            n_checks++; if (rgb !== e.rgb) begin n_fail++; $display("FAIL line_rgb n=%0d: got %h want %h", n, rgb, e.rgb); end
            if (n <= LINE && req === 1'b1) begin
                reqs++;
                n_checks++; if (col !== 10'(exp_col) || row !== row0) begin
                    n_fail++; $display("FAIL line_pos n=%0d: got (%0d,%0d) want (%0d,%0d)", n, col, row, exp_col, row0);
                end
                exp_col++;
            end
            if (n >= 4 && rgb === 8'hA5) on++;
            if (n >= 4 && rgb === 8'h00) off++;
            if (n == LINE + 1) begin
                n_checks++; if (req !== 1'b1 || col !== 10'd0 || row !== row0 + 10'd1) begin
                    n_fail++; $display("FAIL line_next: got req=%b (%0d,%0d) want 1 (0,%0d)", req, col, row, row0 + 10'd1);
                end
            end
            if (n <= LINE + 2) step(); else break;
        end
        n_checks++; if (reqs != HV)      begin n_fail++; $display("FAIL line_reqs: got %0d want %0d", reqs, HV); end
        n_checks++; if (on != HV * CD)   begin n_fail++; $display("FAIL line_rgb_on: got %0d want %0d", on, HV * CD); end
        n_checks++; if (off != (HT - HV) * CD) begin n_fail++; $display("FAIL line_rgb_off: got %0d want %0d", off, (HT - HV) * CD); end
    endtask

    task automatic test_hsync();
        int phase = 0, n0 = 0, nf = 0, nr = 0, nf2 = 0;
        logic [7:0] prev_rgb;
        logic prev_hs;
        exp_t e;
        prev_rgb = rgb;
        prev_hs  = hsync;
        for (int i = 0; i < 4 * LINE && phase < 4; i++) begin
            step();
            e = model(n);
            n_checks++; if (hsync !== e.hs) begin n_fail++; $display("FAIL hs_model n=%0d: got %b want %b", n, hsync, e.hs); end
            case (phase)
                0: if (prev_rgb === 8'h00 && rgb !== 8'h00) begin n0 = n; phase = 1; end
                1: if (prev_hs === 1'b1 && hsync === 1'b0) begin nf = n; phase = 2; end
                2: if (prev_hs === 1'b0 && hsync === 1'b1) begin nr = n; phase = 3; end
                3: if (prev_hs === 1'b1 && hsync === 1'b0) begin nf2 = n; phase = 4; end
                default: ;
            endcase
            prev_rgb = rgb;
            prev_hs  = hsync;
        end
        n_checks++; if (phase != 4) begin n_fail++; $display("FAIL hs_timeout: got phase %0d want 4", phase); end
        else begin
            n_checks++; if (nf - n0 != (HV + HF) * CD) begin n_fail++; $display("FAIL hs_fall: got %0d want %0d", nf - n0, (HV + HF) * CD); end
            n_checks++; if (nr - nf != HS * CD) begin n_fail++; $display("FAIL hs_width: got %0d want %0d", nr - nf, HS * CD); end
            n_checks++; if (nr - n0 != (HV + HF + HS) * CD) begin n_fail++; $display("FAIL hs_rise: got %0d want %0d", nr - n0, (HV + HF + HS) * CD); end
            n_checks++; if (nf2 - nf != LINE) begin n_fail++; $display("FAIL hs_period: got %0d want %0d", nf2 - nf, LINE); end
        end
    endtask

    task automatic test_frame();
        int reqs = 0, fss = 0, vlow = 0, blank_bad = 0, fs_a = -1, fs_b = -1;
        exp_t e;
        pg_mode  = 1'b0;
        pg_const = 8'hFF;
        rst = 1'b1;
        repeat (2) step();
        release_reset();
        while (1) begin
            e = model(n);
            n_checks++; if (vsync !== e.vs) begin n_fail++; $display("FAIL fr_vsync n=%0d: got %b want %b", n, vsync, e.vs); end
            n_checks++; if (rgb !== e.rgb)  begin n_fail++; $display("FAIL fr_rgb n=%0d: got %h want %h", n, rgb, e.rgb); end
            n_checks++; if (frame_start !== e.fs) begin n_fail++; $display("FAIL fr_fs n=%0d: got %b want %b", n, frame_start, e.fs); end
            if (n >= 1 && n <= FRAME) begin
                if (req === 1'b1) reqs++;
                if (frame_start === 1'b1) fss++;
            end
            if (frame_start === 1'b1) begin
                if (fs_a < 0) fs_a = n; else if (fs_b < 0) fs_b = n;
            end
            if (vsync === 1'b0) vlow++;
            if (e.drow >= VV && rgb !== 8'h00) blank_bad++;
            if (n <= FRAME) step(); else break;
        end
        n_checks++; if (reqs != HV * VV) begin n_fail++; $display("FAIL fr_reqs: got %0d want %0d", reqs, HV * VV); end
        n_checks++; if (fss != 1)        begin n_fail++; $display("FAIL fr_fs_count: got %0d want 1", fss); end
        n_checks++; if (vlow != VS * LINE) begin n_fail++; $display("FAIL fr_vlow: got %0d want %0d", vlow, VS * LINE); end
        n_checks++; if (fs_b - fs_a != FRAME) begin n_fail++; $display("FAIL fr_period: got %0d want %0d", fs_b - fs_a, FRAME); end
        n_checks++; if (blank_bad != 0)  begin n_fail++; $display("FAIL fr_blank_rgb: got %0d want 0", blank_bad); end
    endtask

    task automatic test_align();
        exp_t e;
        pg_mode = 1'b1;
        seed    = 8'h00;
        rst = 1'b1;
        repeat ($urandom_range(1, 4)) step();
        release_reset();
        while (n <= VV * LINE + 4) begin
            e = model(n);
            n_checks++; if (rgb !== e.rgb)  begin n_fail++; $display("FAIL al_rgb n=%0d: got %h want %h", n, rgb, e.rgb); end
            n_checks++; if (hsync !== e.hs) begin n_fail++; $display("FAIL al_hsync n=%0d: got %b want %b", n, hsync, e.hs); end
            n_checks++; if (vsync !== e.vs) begin n_fail++; $display("FAIL al_vsync n=%0d: got %b want %b", n, vsync, e.vs); end
            step();
        end
    endtask

    task automatic test_mid_reset();
        int target;
        exp_t e;
        pg_mode = 1'b1;
        seed    = 8'($urandom_range(1, 255));
        if (seed == 8'd42) seed = 8'd43;
        rst = 1'b1;
        repeat (2) step();
        release_reset();
        target = CD * (2 * HT + 300) + (CD - 1);
        while (n < target) begin
            e = model(n);
            n_checks++; if (rgb !== e.rgb || req !== e.req) begin
                n_fail++; $display("FAIL mr_pre n=%0d: got rgb=%h req=%b want %h %b", n, rgb, req, e.rgb, e.req);
            end
            step();
        end
        n_checks++; if (req !== 1'b1 || col !== 10'd300 || row !== 10'd2) begin
            n_fail++; $display("FAIL mr_at: got req=%b (%0d,%0d) want 1 (300,2)", req, col, row);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (req !== 1'b0 || frame_start !== 1'b0) begin n_fail++; $display("FAIL mr_async_req: got %b %b want 0 0", req, frame_start); end
        n_checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin n_fail++; $display("FAIL mr_async_sync: got %b %b want 1 1", hsync, vsync); end
        n_checks++; if (rgb !== 8'h00) begin n_fail++; $display("FAIL mr_async_rgb: got %h want 00", rgb); end
        n_checks++; if (col !== 10'd0 || row !== 10'd0) begin n_fail++; $display("FAIL mr_async_pos: got (%0d,%0d) want (0,0)", col, row); end
        repeat (2) step();
        release_reset();
        while (n <= LINE + 3) begin
            e = model(n);
            n_checks++; if (req !== e.req || frame_start !== e.fs) begin
                n_fail++; $display("FAIL mr_post_req n=%0d: got %b %b want %b %b", n, req, frame_start, e.req, e.fs);
            end
            n_checks++; if (rgb !== e.rgb || hsync !== e.hs) begin
                n_fail++; $display("FAIL mr_post_out n=%0d: got %h %b want %h %b", n, rgb, hsync, e.rgb, e.hs);
            end
            if (n == 1) begin
                n_checks++; if (req !== 1'b1 || frame_start !== 1'b1 || col !== 10'd0 || row !== 10'd0) begin
                    n_fail++; $display("FAIL mr_first: got req=%b fs=%b (%0d,%0d) want 1 1 (0,0)", req, frame_start, col, row);
                end
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_hsync();
        test_frame();
        test_align();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
